cnet_reg_arb: RTL and testbench
===============================

CNET_REG_ARB -- requirements
Module: cnet_reg_arb

Interface -- parameters (name, default, meaning)
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 1000, giving the read timeout in clk cycles (legal range 1..65535).

Interface -- ports (name  direction  width  meaning)
REQ-002 The block SHALL have these ports:
- clk  in  1  single clock for all logic.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  2  per-requester transaction request; bit 0 = PCI target path, bit 1 = internal register engine.
- req_we  in  2  per-requester write (1) or read (0).
- req_addr  in  64  per-requester address; requester k uses bits [32k+31:32k].
- req_wdata  in  64  per-requester write data, same packing as req_addr.
- req_done  out  2  one-cycle completion pulse to the granted requester.
- req_rdata  out  32  read data, valid in the req_done cycle.
- req_err  out  1  timeout/abort flag, valid in the req_done cycle.
- busy  out  1  high in any state other than IDLE.
- p2n_addr  out  32  CNET address.
- p2n_data  out  32  CNET write data.
- p2n_we  out  1  CNET write enable.
- p2n_req  out  1  CNET request strobe.
- p2n_full  in  1  CPCI->CNET FIFO full.
- n2p_data  in  32  CNET read return data.
- n2p_rd_rdy  in  1  read return valid.
- cnet_reprog  in  1  CNET is being reprogrammed.

Function
REQ-003 The FSM SHALL have exactly four states: IDLE, ISSUE, WAIT_RD and DONE.
REQ-004 IDLE arbitration: with one req_valid bit set, that requester SHALL be granted; with both set, the requester not granted last SHALL win (round robin); the FSM then moves to ISSUE on the next edge.
REQ-005 The grant, address, data and we SHALL be latched at the grant edge; the requester SHALL hold its req_* inputs stable until its req_done, and no check is made for violations.
REQ-006 In ISSUE with cnet_reprog=1, p2n_req SHALL stay 0 and the FSM SHALL go to DONE with err=1 and rdata=32'hffff_ffff.
REQ-007 In ISSUE with p2n_full=1, p2n_req SHALL stay 0 and the FSM SHALL remain in ISSUE with no limit.
REQ-008 In ISSUE with p2n_full=0, p2n_req SHALL be 1 for exactly one cycle with p2n_addr/p2n_data/p2n_we driven from the latched values; the next state SHALL be DONE for a write and WAIT_RD for a read.
REQ-009 p2n_addr, p2n_data and p2n_we SHALL be 0 whenever p2n_req=0.
REQ-010 In WAIT_RD, n2p_rd_rdy=1 SHALL capture n2p_data into rdata with err=0, and the FSM SHALL go to DONE.
REQ-011 In WAIT_RD, cnet_reprog=1 (without n2p_rd_rdy) SHALL end the read with rdata=32'hffff_ffff and err=1.
REQ-012 If n2p_rd_rdy and a timeout or cnet_reprog occur in the same cycle, the returned data SHALL win.
REQ-013 In DONE, req_done SHALL pulse for one cycle on the granted bit only, with req_rdata/req_err valid; the next state SHALL be IDLE.
REQ-014 req_rdata SHALL be 0 for writes and SHALL hold its value until the next DONE.
REQ-015 Latency: a write sampled in IDLE with p2n_full=0 SHALL see p2n_req 1 cycle later and req_done 2 cycles later; req_done SHALL follow an accepted n2p_rd_rdy by 1 cycle.
REQ-016 n2p_rd_rdy outside WAIT_RD SHALL be ignored (no state change, no capture).
REQ-017 Back-to-back: after DONE, IDLE SHALL arbitrate on the next edge, so the minimum spacing between p2n_req pulses is 3 cycles.

Reset
REQ-018 While reset_n=0: state=IDLE, last-grant=requester 1 (so requester 0 wins the first tie), timeout counter=0, and all outputs 0, including req_rdata.
REQ-019 Reset asserted mid-transaction SHALL abandon it with no req_done; a late n2p_rd_rdy after reset SHALL be ignored per REQ-016.

Configuration
REQ-020 Macro CNET_REG_ARB_TIMEOUT_EN: when defined, a 16-bit counter SHALL clear on WAIT_RD entry and increment each WAIT_RD cycle; on reaching TIMEOUT_CYCLES without n2p_rd_rdy, the FSM SHALL go to DONE with rdata=32'hffff_ffff and err=1.
REQ-021 When CNET_REG_ARB_TIMEOUT_EN is undefined, no counter SHALL exist and WAIT_RD SHALL exit only on n2p_rd_rdy or cnet_reprog.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- Write on requester 0, addr 0x0000_1234, data 0xdead_beef, p2n_full=0 -> one p2n_req pulse with we=1 and those values; req_done=01 two cycles after grant; err=0.
- Both requesters issue reads in the same cycle, CNET model returns addr[23:0] -> requester 0 served first, then requester 1; each req_rdata equals its addr[23:0].
- p2n_full held high 20 cycles during a write -> no p2n_req for 20 cycles, then exactly one pulse; req_done follows.
- Timeout enabled, TIMEOUT_CYCLES=16, CNET model silent -> req_done after 16 WAIT_RD cycles, rdata=0xffff_ffff, err=1; an n2p_rd_rdy injected afterwards is ignored.
- cnet_reprog=1 during WAIT_RD -> req_done next cycle with rdata=0xffff_ffff, err=1; reset_n pulsed low in ISSUE -> no req_done and all outputs 0.

Source files
------------

// File: rtl/cnet_reg_arb.sv
// Round-robin arbiter sharing the CNET register port between the PCI target path (0)
// and the internal register engine (1). Define CNET_REG_ARB_TIMEOUT_EN to add a read timeout.
module cnet_reg_arb #(
    parameter int unsigned TIMEOUT_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  req_valid,
    input  logic [1:0]  req_we,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic [1:0]  req_done,
    output logic [31:0] req_rdata,
    output logic        req_err,
    output logic        busy,
    output logic [31:0] p2n_addr,
    output logic [31:0] p2n_data,
    output logic        p2n_we,
    output logic        p2n_req,
    input  logic        p2n_full,
    input  logic [31:0] n2p_data,
    input  logic        n2p_rd_rdy,
    input  logic        cnet_reprog
);

    localparam int unsigned DW = 32;
    localparam int unsigned CW = 16;
    localparam logic [DW-1:0] ABORT_DATA = 32'hffff_ffff;

    if (TIMEOUT_CYCLES == 0 || TIMEOUT_CYCLES > 32'd65535) begin : g_bad_timeout
        $error("cnet_reg_arb: TIMEOUT_CYCLES must be within 1..65535");
    end

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT_RD = 2'd2,
        DONE    = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic            grant_q, grant_d;
    logic            last_q, last_d;
    logic            we_q, we_d;
    logic [DW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [DW-1:0]   rdata_q, rdata_d;
    logic            err_q, err_d;
    logic [1:0]      done_q, done_d;
    logic            busy_q, busy_d;
    logic            grant_c;
    logic            issue_c;
    logic            timeout_c;

    // Round robin: on a tie the requester that was not served last wins.
    always_comb begin
        grant_c = req_valid[1];
        if (req_valid == 2'b11) begin
            grant_c = ~last_q;
        end
    end

`ifdef CNET_REG_ARB_TIMEOUT_EN
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == ISSUE) begin
            cnt_d = '0;
        end else if (state_q == WAIT_RD) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign timeout_c = ((32'(cnt_q) + 32'd1) == TIMEOUT_CYCLES);
`else
    assign timeout_c = 1'b0;
`endif

    // Next-state and transaction bookkeeping.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        done_d  = 2'b00;
        issue_c = 1'b0;

        case (state_q)
            IDLE: begin
                if (|req_valid) begin
                    grant_d = grant_c;
                    last_d  = grant_c;
                    we_d    = req_we[grant_c];
                    addr_d  = grant_c ? req_addr[63:32]  : req_addr[31:0];
                    wdata_d = grant_c ? req_wdata[63:32] : req_wdata[31:0];
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (cnet_reprog) begin
                    rdata_d = ABORT_DATA;
                    err_d   = 1'b1;
                    state_d = DONE;
                end else if (!p2n_full) begin
                    issue_c = 1'b1;
                    if (we_q) begin
                        rdata_d = '0;
                        err_d   = 1'b0;
                        state_d = DONE;
                    end else begin
                        state_d = WAIT_RD;
                    end
                end
            end
            WAIT_RD: begin
                // Returned data beats a simultaneous abort or timeout.
                if (n2p_rd_rdy) begin
                    rdata_d = n2p_data;
                    err_d   = 1'b0;
                    state_d = DONE;
                end else if (cnet_reprog || timeout_c) begin
                    rdata_d = ABORT_DATA;
                    err_d   = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (state_d == DONE) begin
            done_d = grant_d ? 2'b10 : 2'b01;
        end
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            grant_q <= 1'b0;
            last_q  <= 1'b1;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            done_q  <= 2'b00;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign req_done  = done_q;
    assign req_rdata = rdata_q;
    assign req_err   = err_q;
    assign busy      = busy_q;

    // CNET bus is driven only during the single issue cycle.
    assign p2n_req  = issue_c;
    assign p2n_we   = issue_c & we_q;
    assign p2n_addr = issue_c ? addr_q  : '0;
    assign p2n_data = issue_c ? wdata_q : '0;

endmodule

// File: tb/tb_cnet_reg_arb.sv
// Self-checking bench for cnet_reg_arb: directed scenarios followed by randomized
// traffic checked against a transaction-level model of the arbiter.
module tb_cnet_reg_arb;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  req_valid, req_we;
    logic [63:0] req_addr, req_wdata;
    logic [1:0]  req_done;
    logic [31:0] req_rdata;
    logic        req_err, busy;
    logic [31:0] p2n_addr, p2n_data;
    logic        p2n_we, p2n_req, p2n_full;
    logic [31:0] n2p_data;
    logic        n2p_rd_rdy, cnet_reprog;

    int n_assert = 0;
    int n_fail   = 0;

    logic        we_m   [2];
    logic [31:0] addr_m [2];
    logic [31:0] data_m [2];
    int          last_m;

    always #5 clk = ~clk;

    cnet_reg_arb #(.TIMEOUT_CYCLES(16)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_done   (req_done),
        .req_rdata  (req_rdata),
        .req_err    (req_err),
        .busy       (busy),
        .p2n_addr   (p2n_addr),
        .p2n_data   (p2n_data),
        .p2n_we     (p2n_we),
        .p2n_req    (p2n_req),
        .p2n_full   (p2n_full),
        .n2p_data   (n2p_data),
        .n2p_rd_rdy (n2p_rd_rdy),
        .cnet_reprog(cnet_reprog)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        req_we    = {we_m[1], we_m[0]};
        req_addr  = {addr_m[1], addr_m[0]};
        req_wdata = {data_m[1], data_m[0]};
    endtask

    task automatic set_req(input int k, input logic we, input logic [31:0] a, input logic [31:0] d);
        we_m[k] = we; addr_m[k] = a; data_m[k] = d;
        drive();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ctl"}, 64'({req_done, req_err, busy, p2n_we, p2n_req, req_rdata}), 64'd0);
        chk({tag, "_bus"}, {p2n_addr, p2n_data}, 64'd0);
    endtask

    task automatic do_reset();
        reset_n = 1'b0; req_valid = 2'b00; p2n_full = 1'b0;
        n2p_data = '0; n2p_rd_rdy = 1'b0; cnet_reprog = 1'b0;
        for (int k = 0; k < 2; k++) set_req(k, 1'b0, 32'd0, 32'd0);
        repeat (3) @(negedge clk);
        #1;
        chk_all_zero("reset_outputs");
        reset_n = 1'b1;
        last_m = 1;
    endtask

    task automatic wait_p2n(input int budget, output int n);
        n = 0;
        do begin
            @(negedge clk); #1; n++;
        end while (!p2n_req && n < budget);
    endtask

    // Spec-level round robin: a lone requester wins; on a tie the one not served last.
    function automatic int arb(input logic [1:0] v, input int last);
        if (v == 2'b11) return (last == 0) ? 1 : 0;
        return v[1] ? 1 : 0;
    endfunction

    initial begin
        int n;
        int pulses;
        bit seen_done, seen_busy;

        // 1: single write on requester 0
        do_reset();
        set_req(0, 1'b1, 32'h0000_1234, 32'hdead_beef);
        @(negedge clk); req_valid = 2'b01; #1;
        chk("d1_idle_no_req", 64'(p2n_req), 64'd0);
        @(negedge clk); #1;
        chk("d1_p2n_req", 64'(p2n_req), 64'd1);
        chk("d1_p2n_addr", 64'(p2n_addr), 64'h0000_1234);
        chk("d1_p2n_data", 64'(p2n_data), 64'hdead_beef);
        chk("d1_p2n_we", 64'(p2n_we), 64'd1);
        chk("d1_busy", 64'(busy), 64'd1);
        @(negedge clk); #1;
        chk("d1_single_pulse", 64'(p2n_req), 64'd0);
        chk("d1_done", 64'(req_done), 64'b01);
        chk("d1_err", 64'(req_err), 64'd0);
        chk("d1_rdata_write", 64'(req_rdata), 64'd0);
        req_valid = 2'b00;
        @(negedge clk); #1;
        chk("d1_done_one_cycle", 64'(req_done), 64'd0);
        chk("d1_idle_busy", 64'(busy), 64'd0);

        // 2: simultaneous reads, CNET returns addr[23:0]
        do_reset();
        set_req(0, 1'b0, 32'h5a12_3456, 32'h1111_1111);
        set_req(1, 1'b0, 32'ha5fe_dcba, 32'h2222_2222);
        @(negedge clk); req_valid = 2'b11;
        for (int g = 0; g < 2; g++) begin
            wait_p2n(10, n);
            chk("d2_p2n_req", 64'(p2n_req), 64'd1);
            chk("d2_p2n_addr", 64'(p2n_addr), 64'(addr_m[g]));
            chk("d2_p2n_we", 64'(p2n_we), 64'd0);
            @(negedge clk); n2p_rd_rdy = 1'b1; n2p_data = {8'h00, addr_m[g][23:0]}; #1;
            chk("d2_no_early_done", 64'(req_done), 64'd0);
            @(negedge clk); n2p_rd_rdy = 1'b0; n2p_data = '0; #1;
            chk("d2_done_order", 64'(req_done), (g == 0) ? 64'b01 : 64'b10);
            chk("d2_rdata", 64'(req_rdata), 64'({8'h00, addr_m[g][23:0]}));
            chk("d2_err", 64'(req_err), 64'd0);
            req_valid[g] = 1'b0;
        end

        // 3: back-pressure from a full CNET FIFO
        set_req(1, 1'b1, 32'h0000_0abc, 32'h0123_4567);
        @(negedge clk); req_valid = 2'b10; p2n_full = 1'b1;
        pulses = 0;
        repeat (20) begin
            @(negedge clk); #1;
            if (p2n_req) pulses++;
        end
        chk("d3_no_req_while_full", 64'(pulses), 64'd0);
        chk("d3_busy_while_full", 64'(busy), 64'd1);
        @(negedge clk); p2n_full = 1'b0; #1;
        chk("d3_req_after_full", 64'(p2n_req), 64'd1);
        chk("d3_p2n_data", 64'(p2n_data), 64'h0123_4567);
        @(negedge clk); #1;
        chk("d3_single_pulse", 64'(p2n_req), 64'd0);
        chk("d3_done", 64'(req_done), 64'b10);
        req_valid = 2'b00;

        // 4: silent CNET on a read
        set_req(0, 1'b0, 32'h0000_4444, 32'h0);
        @(negedge clk); req_valid = 2'b01;
        wait_p2n(10, n);
        chk("d4_p2n_req", 64'(p2n_req), 64'd1);
        n = 0;
        do begin
            @(negedge clk); #1; n++;
        end while (req_done == 2'b00 && n < 100);
`ifdef CNET_REG_ARB_TIMEOUT_EN
        chk("d4_timeout_latency", 64'(n), 64'd17);
        chk("d4_timeout_done", 64'(req_done), 64'b01);
        chk("d4_timeout_rdata", 64'(req_rdata), 64'hffff_ffff);
        chk("d4_timeout_err", 64'(req_err), 64'd1);
        req_valid = 2'b00;
        @(negedge clk); n2p_rd_rdy = 1'b1; n2p_data = 32'h1234_5678; #1;
        @(negedge clk); n2p_rd_rdy = 1'b0; #1;
        chk("d4_late_rdy_busy", 64'(busy), 64'd0);
        chk("d4_late_rdy_done", 64'(req_done), 64'd0);
        chk("d4_late_rdy_rdata", 64'(req_rdata), 64'hffff_ffff);
`else
        chk("d4_no_timeout_done", 64'(req_done), 64'd0);
        chk("d4_no_timeout_busy", 64'(busy), 64'd1);
        n2p_rd_rdy = 1'b1; n2p_data = 32'h0000_4444;
        @(negedge clk); n2p_rd_rdy = 1'b0; #1;
        chk("d4_late_data_done", 64'(req_done), 64'b01);
        chk("d4_late_data_rdata", 64'(req_rdata), 64'h0000_4444);
        req_valid = 2'b00;
`endif

        // 5a: reprogramming aborts a read in WAIT_RD and a write in ISSUE
        set_req(1, 1'b0, 32'h0000_7777, 32'h0);
        @(negedge clk); req_valid = 2'b10;
        wait_p2n(10, n);
        chk("d5_p2n_req", 64'(p2n_req), 64'd1);
        @(negedge clk); cnet_reprog = 1'b1; #1;
        chk("d5_wait_busy", 64'(busy), 64'd1);
        @(negedge clk); cnet_reprog = 1'b0; #1;
        chk("d5_reprog_done", 64'(req_done), 64'b10);
        chk("d5_reprog_rdata", 64'(req_rdata), 64'hffff_ffff);
        chk("d5_reprog_err", 64'(req_err), 64'd1);
        req_valid = 2'b00;
        set_req(0, 1'b1, 32'h0000_0010, 32'hcafe_f00d);
        @(negedge clk); req_valid = 2'b01; cnet_reprog = 1'b1;
        @(negedge clk); #1;
        chk("d5_issue_reprog_no_req", 64'(p2n_req), 64'd0);
        @(negedge clk); #1;
        chk("d5_issue_reprog_done", 64'(req_done), 64'b01);
        chk("d5_issue_reprog_err", 64'(req_err), 64'd1);
        cnet_reprog = 1'b0; req_valid = 2'b00;

        // 5b: reset while stalled in ISSUE
        @(negedge clk); req_valid = 2'b01; p2n_full = 1'b1;
        @(negedge clk); #1;
        chk("d5_stalled_busy", 64'(busy), 64'd1);
        @(negedge clk); reset_n = 1'b0; #1;
        chk_all_zero("d5_reset_mid");
        @(negedge clk); req_valid = 2'b00; p2n_full = 1'b0; reset_n = 1'b1; last_m = 1;
        seen_done = 1'b0; seen_busy = 1'b0;
        @(negedge clk); n2p_rd_rdy = 1'b1; n2p_data = 32'h9999_9999;
        repeat (5) begin
            @(negedge clk); n2p_rd_rdy = 1'b0; #1;
            seen_done |= (req_done != 2'b00);
            seen_busy |= busy;
        end
        chk("d5_no_done_after_reset", 64'(seen_done), 64'd0);
        chk("d5_idle_after_reset", 64'(seen_busy), 64'd0);
        chk("d5_rdata_cleared", 64'(req_rdata), 64'd0);

        // 6: randomized traffic against the transaction model
        begin : rand_phase
            int cycles, txn, last_issue, rd_dly, eg;
            bit rd_pend;
            logic [31:0] rd_data;
            cycles = 0; txn = 0; last_issue = -100; rd_dly = 0; rd_pend = 1'b0; rd_data = '0;
            do_reset();
            for (int k = 0; k < 2; k++)
                set_req(k, 1'($urandom_range(1)), $urandom, $urandom);
            req_valid = 2'($urandom_range(1, 3));
            eg = arb(req_valid, last_m);
            while (txn < 150 && cycles < 8000) begin
                @(negedge clk); cycles++;
                p2n_full = ($urandom_range(3) == 0);
                if (rd_pend && rd_dly == 0) begin
                    n2p_rd_rdy = 1'b1; n2p_data = rd_data; rd_pend = 1'b0;
                end else begin
                    n2p_rd_rdy = 1'b0; n2p_data = $urandom;
                    if (rd_pend) rd_dly--;
                end
                #1;
                if (p2n_req) begin
                    chk("r_spacing", 64'(cycles - last_issue >= 3), 64'd1);
                    chk("r_p2n_addr", 64'(p2n_addr), 64'(addr_m[eg]));
                    chk("r_p2n_data", 64'(p2n_data), 64'(data_m[eg]));
                    chk("r_p2n_we", 64'(p2n_we), 64'(we_m[eg]));
                    last_issue = cycles;
                    if (!we_m[eg]) begin
                        rd_pend = 1'b1; rd_dly = $urandom_range(4);
                        rd_data = {8'h00, addr_m[eg][23:0]};
                    end
                end else begin
                    chk("r_bus_quiet", 64'(p2n_addr | p2n_data) | 64'(p2n_we), 64'd0);
                end
                if (req_done != 2'b00) begin
                    chk("r_done_grant", 64'(req_done), (eg == 0) ? 64'b01 : 64'b10);
                    chk("r_rdata", 64'(req_rdata),
                        we_m[eg] ? 64'd0 : 64'({8'h00, addr_m[eg][23:0]}));
                    chk("r_err", 64'(req_err), 64'd0);
                    last_m = eg; txn++;
                    req_valid[eg] = 1'b0;
                    for (int k = 0; k < 2; k++) begin
                        if (!req_valid[k] && $urandom_range(1) == 1) begin
                            set_req(k, 1'($urandom_range(1)), $urandom, $urandom);
                            req_valid[k] = 1'b1;
                        end
                    end
                    if (req_valid == 2'b00) begin
                        eg = $urandom_range(1);
                        set_req(eg, 1'($urandom_range(1)), $urandom, $urandom);
                        req_valid[eg] = 1'b1;
                    end
                    eg = arb(req_valid, last_m);
                end
            end
            chk("r_txn_count", 64'(txn), 64'd150);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
